// File: rtl/pkt_hdr_arbiter.sv
// Packet-granular round-robin arbiter that merges NUM_PORTS AXI4-Stream
// inputs onto one 512-bit output. It also parses the first beat of each
// granted packet into a one-entry header-result register.
//
// Handshake semantics (all streams and the header slot): a transfer happens
// on a rising clock edge where valid and ready are both 1. A source never
// withdraws valid or changes payload while waiting for ready. Ready may
// depend combinationally on valid.
module pkt_hdr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ID_W      = 3
) (
    input  logic                     axis_aclk,
    input  logic                     axis_aresetn,
    input  logic [NUM_PORTS-1:0]     s_axis_tvalid,
    input  logic [NUM_PORTS*512-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*64-1:0]  s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]     s_axis_tlast,
    output logic [NUM_PORTS-1:0]     s_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [511:0]             m_axis_tdata,
    output logic [63:0]              m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic [ID_W-1:0]          m_axis_tdest,
    input  logic                     m_axis_tready,
    output logic                     hdr_valid,
    input  logic                     hdr_ready,
    output logic [ID_W-1:0]          hdr_port,
    output logic [1:0]               hdr_class,
    output logic [7:0]               hdr_l4_proto,
    output logic                     hdr_ports_valid,
    output logic [15:0]              hdr_src_port,
    output logic [15:0]              hdr_dst_port,
    output logic                     dbg_state_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } state_e;

    state_e          state_q, state_d;
    // rr_q is both the round-robin pointer and the active grant in PASS.
    logic [ID_W-1:0] rr_q, rr_d;
    // Set at grant, cleared once the first beat of the packet has been parsed.
    logic            first_q, first_d;

    logic            hdr_valid_q, hdr_valid_d;
    logic [ID_W-1:0] hdr_port_q, hdr_port_d;
    logic [1:0]      hdr_class_q, hdr_class_d;
    logic [7:0]      hdr_proto_q, hdr_proto_d;
    logic            hdr_pv_q, hdr_pv_d;
    logic [15:0]     hdr_src_q, hdr_src_d;
    logic [15:0]     hdr_dst_q, hdr_dst_d;

    logic            sel_valid;
    logic            sel_last;
    logic [511:0]    sel_data;
    logic [63:0]     sel_keep;

    logic [ID_W-1:0] pick;
    logic            found_hi;
    logic            found_lo;
    logic [ID_W-1:0] pick_hi;
    logic [ID_W-1:0] pick_lo;

    logic [15:0]     eth_type;
    logic [1:0]      p_class;
    logic [7:0]      p_proto;
    logic            p_pv;
    logic [15:0]     p_src;
    logic [15:0]     p_dst;

    logic            slot_free;
    logic            beat_acc;

    // Select the stream of the currently granted port (constant-index mux).
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rr_q == ID_W'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_data  = s_axis_tdata[i*512 +: 512];
                sel_keep  = s_axis_tkeep[i*64 +: 64];
            end
        end
    end

    // Round-robin search: lowest requester above rr, else lowest at or below rr.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (s_axis_tvalid[i]) begin
                if (ID_W'(i) > rr_q) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        pick_hi  = ID_W'(i);
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    pick_lo  = ID_W'(i);
                end
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    assign eth_type = sel_data[415:400];

    // Decode the big-endian Ethernet/IP header fields of the selected beat.
    always_comb begin
        p_class = 2'd0;
        p_proto = 8'h00;
        p_pv    = 1'b0;
        p_src   = 16'h0000;
        p_dst   = 16'h0000;
        if (eth_type == 16'h0800) begin
            p_class = 2'd1;
            p_proto = sel_data[327:320];
            p_src   = sel_data[239:224];
            p_dst   = sel_data[223:208];
            // Fixed port offsets are only valid for an option-less IPv4 header.
            p_pv    = ((p_proto == 8'h06) || (p_proto == 8'h11)) &&
                      (sel_data[395:392] == 4'd5);
        end else if (eth_type == 16'h86DD) begin
            p_class = 2'd2;
            p_proto = sel_data[351:344];
            p_src   = sel_data[79:64];
            p_dst   = sel_data[63:48];
            p_pv    = (p_proto == 8'h06) || (p_proto == 8'h11);
        end
    end

    assign slot_free = !hdr_valid_q || hdr_ready;
    assign beat_acc  = (state_q == ST_PASS) && sel_valid && m_axis_tready;

    // Next-state logic, datapath steering and header-slot update.
    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        first_d       = first_q;
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tdest  = '0;

        hdr_valid_d   = hdr_valid_q;
        hdr_port_d    = hdr_port_q;
        hdr_class_d   = hdr_class_q;
        hdr_proto_d   = hdr_proto_q;
        hdr_pv_d      = hdr_pv_q;
        hdr_src_d     = hdr_src_q;
        hdr_dst_d     = hdr_dst_q;

        if (hdr_valid_q && hdr_ready) begin
            hdr_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // A full header slot stalls arbitration, which backpressures every port.
                if ((|s_axis_tvalid) && slot_free) begin
                    rr_d    = pick;
                    first_d = 1'b1;
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                m_axis_tvalid = sel_valid;
                m_axis_tdata  = sel_data;
                m_axis_tkeep  = sel_keep;
                m_axis_tlast  = sel_last;
                m_axis_tdest  = rr_q;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (rr_q == ID_W'(i)) begin
                        s_axis_tready[i] = m_axis_tready;
                    end
                end
                if (beat_acc) begin
                    if (first_q) begin
                        first_d     = 1'b0;
                        hdr_valid_d = 1'b1;
                        hdr_port_d  = rr_q;
                        hdr_class_d = p_class;
                        hdr_proto_d = p_proto;
                        hdr_pv_d    = p_pv;
                        hdr_src_d   = p_src;
                        hdr_dst_d   = p_dst;
                    end
                    if (sel_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant pointer and header-slot registers.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q     <= ST_IDLE;
            rr_q        <= ID_W'(NUM_PORTS - 1);
            first_q     <= 1'b0;
            hdr_valid_q <= 1'b0;
            hdr_port_q  <= '0;
            hdr_class_q <= 2'd0;
            hdr_proto_q <= 8'h00;
            hdr_pv_q    <= 1'b0;
            hdr_src_q   <= 16'h0000;
            hdr_dst_q   <= 16'h0000;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            first_q     <= first_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_port_q  <= hdr_port_d;
            hdr_class_q <= hdr_class_d;
            hdr_proto_q <= hdr_proto_d;
            hdr_pv_q    <= hdr_pv_d;
            hdr_src_q   <= hdr_src_d;
            hdr_dst_q   <= hdr_dst_d;
        end
    end

    assign hdr_valid       = hdr_valid_q;
    assign hdr_port        = hdr_port_q;
    assign hdr_class       = hdr_class_q;
    assign hdr_l4_proto    = hdr_proto_q;
    assign hdr_ports_valid = hdr_pv_q;
    assign hdr_src_port    = hdr_src_q;
    assign hdr_dst_port    = hdr_dst_q;
    assign dbg_state_o     = (state_q == ST_PASS);

endmodule

// File: tb/tb_pkt_hdr_arbiter.sv
// Bench for pkt_hdr_arbiter: header-decode vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction model.
module tb_pkt_hdr_arbiter;
  localparam int NP  = 2;
  localparam int IDW = 3;
  localparam int BW  = 577; // {tlast, tkeep, tdata}

  logic               clk;
  logic               rst_n;
  logic [NP-1:0]      s_axis_tvalid;
  logic [NP*512-1:0]  s_axis_tdata;
  logic [NP*64-1:0]   s_axis_tkeep;
  logic [NP-1:0]      s_axis_tlast;
  logic [NP-1:0]      s_axis_tready;
  logic               m_axis_tvalid;
  logic [511:0]       m_axis_tdata;
  logic [63:0]        m_axis_tkeep;
  logic               m_axis_tlast;
  logic [IDW-1:0]     m_axis_tdest;
  logic               m_axis_tready;
  logic               hdr_valid;
  logic               hdr_ready;
  logic [IDW-1:0]     hdr_port;
  logic [1:0]         hdr_class;
  logic [7:0]         hdr_l4_proto;
  logic               hdr_ports_valid;
  logic [15:0]        hdr_src_port;
  logic [15:0]        hdr_dst_port;
  logic               dbg_state;

  pkt_hdr_arbiter #(.NUM_PORTS(NP), .ID_W(IDW)) dut (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdest(m_axis_tdest), .m_axis_tready(m_axis_tready),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_port(hdr_port),
    .hdr_class(hdr_class), .hdr_l4_proto(hdr_l4_proto),
    .hdr_ports_valid(hdr_ports_valid), .hdr_src_port(hdr_src_port),
    .hdr_dst_port(hdr_dst_port), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #2 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [BW-1:0] src_q[NP][$];  // beats still to be offered per port
  logic [BW-1:0] exp_q[NP][$];  // scoreboard: beats expected at the output per port

  int p_valid  = 100;
  int p_mready = 100;
  int p_hready = 100;

  // Inputs/outputs captured at the sampling edge
  logic [NP-1:0]     c_valid, c_last, c_acc;
  logic [NP*512-1:0] c_data;
  logic [NP*64-1:0]  c_keep;
  logic              c_mready, c_hready, c_rst;

  // ---------------- reference model ----------------
  typedef struct {
    bit v; int port; int cls; int proto; bit pv; int src; int dst;
  } mhdr_t;

  int    m_owner;  // -1 when no packet is being forwarded
  int    m_rr;
  bit    m_need;
  mhdr_t m_hdr;

  function automatic logic [7:0] byt(input logic [511:0] d, input int n);
    return d[511-8*n -: 8];
  endfunction

  function automatic logic [511:0] setb(input logic [511:0] d, input int n, input logic [7:0] v);
    d[511-8*n -: 8] = v;
    return d;
  endfunction

  function automatic mhdr_t parse(input logic [511:0] d, input int port);
    mhdr_t h;
    logic [15:0] et;
    logic [7:0]  b14;
    h = '{default: 0};
    h.v = 1'b1;
    h.port = port;
    et = {byt(d, 12), byt(d, 13)};
    if (et == 16'h0800) begin
      b14 = byt(d, 14);
      h.cls = 1;
      h.proto = int'(byt(d, 23));
      h.src = int'({byt(d, 34), byt(d, 35)});
      h.dst = int'({byt(d, 36), byt(d, 37)});
      h.pv = (h.proto == 6 || h.proto == 17) && (b14[3:0] == 4'd5);
    end else if (et == 16'h86DD) begin
      h.cls = 2;
      h.proto = int'(byt(d, 20));
      h.src = int'({byt(d, 54), byt(d, 55)});
      h.dst = int'({byt(d, 56), byt(d, 57)});
      h.pv = (h.proto == 6 || h.proto == 17);
    end
    return h;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_rr = NP - 1;
    m_need = 1'b0;
    m_hdr = '{default: 0};
  endtask

  task automatic model_update();
    bit free;
    int p;
    free = !m_hdr.v || c_hready;
    if (m_hdr.v && c_hready) m_hdr.v = 1'b0;
    if (m_owner < 0) begin
      if ((|c_valid) && free) begin
        for (int k = 1; k <= NP; k++) begin
          p = (m_rr + k) % NP;
          if (m_owner < 0 && c_valid[p]) m_owner = p;
        end
        m_rr = m_owner;
        m_need = 1'b1;
      end
    end else if (c_valid[m_owner] && c_mready) begin
      if (m_need) begin
        m_hdr = parse(c_data[m_owner*512 +: 512], m_owner);
        m_need = 1'b0;
      end
      if (c_last[m_owner]) m_owner = -1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic sample();
    logic [NP-1:0] e_rdy;
    logic [BW-1:0] e_beat;
    int d;
    @(negedge clk);
    c_valid = s_axis_tvalid; c_last = s_axis_tlast; c_data = s_axis_tdata;
    c_keep = s_axis_tkeep; c_mready = m_axis_tready; c_hready = hdr_ready;
    c_rst = rst_n; c_acc = s_axis_tvalid & s_axis_tready;
    if (m_owner < 0) begin
      chk("m_tvalid", m_axis_tvalid, 0);
      chk("m_tdata", m_axis_tdata, 0);
      chk("m_tkeep", m_axis_tkeep, 0);
      chk("m_tlast", m_axis_tlast, 0);
      chk("m_tdest", m_axis_tdest, 0);
      chk("s_tready", s_axis_tready, 0);
    end else begin
      e_rdy = '0;
      e_rdy[m_owner] = c_mready;
      chk("m_tvalid", m_axis_tvalid, c_valid[m_owner]);
      chk("m_tdata", m_axis_tdata, c_data[m_owner*512 +: 512]);
      chk("m_tkeep", m_axis_tkeep, c_keep[m_owner*64 +: 64]);
      chk("m_tlast", m_axis_tlast, c_last[m_owner]);
      chk("m_tdest", m_axis_tdest, m_owner);
      chk("s_tready", s_axis_tready, e_rdy);
    end
    chk("dbg_state", dbg_state, m_owner >= 0);
    chk("hdr_valid", hdr_valid, m_hdr.v);
    chk("hdr_port", hdr_port, m_hdr.port);
    chk("hdr_class", hdr_class, m_hdr.cls);
    chk("hdr_proto", hdr_l4_proto, m_hdr.proto);
    chk("hdr_pv", hdr_ports_valid, m_hdr.pv);
    chk("hdr_src", hdr_src_port, m_hdr.src);
    chk("hdr_dst", hdr_dst_port, m_hdr.dst);
    if (m_axis_tvalid && m_axis_tready) begin
      d = int'(m_axis_tdest);
      if (d < NP && exp_q[d].size() > 0) begin
        e_beat = exp_q[d].pop_front();
        chk("sb_beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, e_beat);
      end else begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got beat on tdest %0d, want none", d);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic advance();
    @(posedge clk);
    if (c_rst) model_update();
    for (int p = 0; p < NP; p++)
      if (c_acc[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
    #1;
  endtask

  task automatic drive();
    logic [BW-1:0] h;
    bit hold;
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0) begin
        h = src_q[p][0];
        hold = s_axis_tvalid[p] && !c_acc[p];
        s_axis_tvalid[p] = hold || ($urandom_range(99) < p_valid);
        s_axis_tdata[p*512 +: 512] = h[511:0];
        s_axis_tkeep[p*64 +: 64] = h[575:512];
        s_axis_tlast[p] = h[576];
      end else begin
        s_axis_tvalid[p] = 1'b0;
        s_axis_tdata[p*512 +: 512] = '0;
        s_axis_tkeep[p*64 +: 64] = '0;
        s_axis_tlast[p] = 1'b0;
      end
    end
    m_axis_tready = ($urandom_range(99) < p_mready);
    hdr_ready = ($urandom_range(99) < p_hready);
  endtask

  task automatic tick();
    sample();
    advance();
    drive();
  endtask

  task automatic gen_pkt(input int port, input int nb, input logic [15:0] et,
                         input logic [3:0] ihl, input logic [7:0] proto,
                         input logic [15:0] src, input logic [15:0] dst,
                         output logic [511:0] first);
    logic [511:0] d;
    logic [63:0] k;
    for (int b = 0; b < nb; b++) begin
      for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
      k = {$urandom(), $urandom()};
      if (b == 0) begin
        d = setb(d, 12, et[15:8]);
        d = setb(d, 13, et[7:0]);
        if (et == 16'h0800) begin
          d = setb(d, 14, {4'h4, ihl});
          d = setb(d, 23, proto);
          d = setb(d, 34, src[15:8]); d = setb(d, 35, src[7:0]);
          d = setb(d, 36, dst[15:8]); d = setb(d, 37, dst[7:0]);
        end else if (et == 16'h86DD) begin
          d = setb(d, 20, proto);
          d = setb(d, 54, src[15:8]); d = setb(d, 55, src[7:0]);
          d = setb(d, 56, dst[15:8]); d = setb(d, 57, dst[7:0]);
        end
        first = d;
      end
      src_q[port].push_back({b == nb - 1, k, d});
      exp_q[port].push_back({b == nb - 1, k, d});
    end
  endtask

  // ---------------- header-decode vector table ----------------
  typedef struct {
    logic [15:0] et; logic [3:0] ihl; logic [7:0] proto; logic [15:0] src; logic [15:0] dst;
    logic [1:0] e_cls; logic [7:0] e_proto; logic e_pv; logic [15:0] e_src; logic [15:0] e_dst;
  } vec_t;

  vec_t tbl[8];

  // ---------------- test sequence ----------------
  initial begin
    logic [511:0] d0;
    logic [NP-1:0] e_rdy;
    int cyc;
    int sel;
    logic [7:0] pr;

    tbl[0] = '{16'h0800, 4'd5, 8'h11, 16'h1234, 16'h0050, 2'd1, 8'h11, 1'b1, 16'h1234, 16'h0050};
    tbl[1] = '{16'h86DD, 4'd0, 8'h06, 16'hABCD, 16'h01BB, 2'd2, 8'h06, 1'b1, 16'hABCD, 16'h01BB};
    tbl[2] = '{16'h88CC, 4'd5, 8'h11, 16'h1111, 16'h2222, 2'd0, 8'h00, 1'b0, 16'h0000, 16'h0000};
    tbl[3] = '{16'h0800, 4'd6, 8'h06, 16'h4444, 16'h5555, 2'd1, 8'h06, 1'b0, 16'h4444, 16'h5555};
    tbl[4] = '{16'h0800, 4'd5, 8'h01, 16'h7777, 16'h8888, 2'd1, 8'h01, 1'b0, 16'h7777, 16'h8888};
    tbl[5] = '{16'h86DD, 4'd0, 8'h3A, 16'h9999, 16'hAAAA, 2'd2, 8'h3A, 1'b0, 16'h9999, 16'hAAAA};
    tbl[6] = '{16'h86DD, 4'd0, 8'h11, 16'hC000, 16'h0035, 2'd2, 8'h11, 1'b1, 16'hC000, 16'h0035};
    tbl[7] = '{16'h0800, 4'd5, 8'h06, 16'hFFFF, 16'h0000, 2'd1, 8'h06, 1'b1, 16'hFFFF, 16'h0000};

    rst_n = 1'b0;
    s_axis_tvalid = '0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = '0;
    m_axis_tready = 1'b0; hdr_ready = 1'b0;
    c_acc = '0;
    model_reset();
    repeat (3) @(posedge clk);

    // Reset state
    sample();
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_hdr_valid", hdr_valid, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    rst_n = 1'b1;
    advance();
    drive();

    // Single-beat packets on port 0 through the header decoder
    for (int i = 0; i < 8; i++) begin
      gen_pkt(0, 1, tbl[i].et, tbl[i].ihl, tbl[i].proto, tbl[i].src, tbl[i].dst, d0);
      drive();
      tick();                              // grant cycle
      sample();                            // pass-through beat
      chk("tbl_m_tvalid", m_axis_tvalid, 1);
      chk("tbl_m_tdata", m_axis_tdata, d0);
      chk("tbl_m_tdest", m_axis_tdest, 0);
      chk("tbl_m_tlast", m_axis_tlast, 1);
      advance(); drive();
      sample();                            // header result visible
      chk("tbl_hdr_valid", hdr_valid, 1);
      chk("tbl_hdr_class", hdr_class, tbl[i].e_cls);
      chk("tbl_hdr_proto", hdr_l4_proto, tbl[i].e_proto);
      chk("tbl_hdr_pv", hdr_ports_valid, tbl[i].e_pv);
      chk("tbl_hdr_src", hdr_src_port, tbl[i].e_src);
      chk("tbl_hdr_dst", hdr_dst_port, tbl[i].e_dst);
      advance(); drive();
    end

    // Three-beat IPv6/TCP packet on port 1
    gen_pkt(1, 3, 16'h86DD, 4'd0, 8'h06, 16'hABCD, 16'h01BB, d0);
    drive();
    tick();
    for (int b = 0; b < 3; b++) begin
      sample();
      chk("v6_m_tvalid", m_axis_tvalid, 1);
      chk("v6_m_tdest", m_axis_tdest, 1);
      chk("v6_m_tlast", m_axis_tlast, b == 2);
      advance(); drive();
    end
    sample();
    chk("v6_hdr_class", hdr_class, 2);
    chk("v6_hdr_proto", hdr_l4_proto, 8'h06);
    chk("v6_hdr_pv", hdr_ports_valid, 1);
    chk("v6_hdr_port", hdr_port, 1);
    advance(); drive();

    // Both ports continuously requesting 2-beat packets: strict alternation
    for (int r = 0; r < 2; r++) begin
      gen_pkt(0, 2, 16'h0800, 4'd5, 8'h11, 16'h0100 + 16'(r), 16'h0200, d0);
      gen_pkt(1, 2, 16'h0800, 4'd5, 8'h06, 16'h0300 + 16'(r), 16'h0400, d0);
    end
    drive();
    for (int c = 0; c < 12; c++) begin
      sample();
      if (c % 3 == 0) begin
        chk("alt_bubble_tvalid", m_axis_tvalid, 0);
        chk("alt_bubble_tready", s_axis_tready, 0);
      end else begin
        e_rdy = '0;
        e_rdy[(c / 3) % 2] = 1'b1;
        chk("alt_tvalid", m_axis_tvalid, 1);
        chk("alt_tdest", m_axis_tdest, (c / 3) % 2);
        chk("alt_tlast", m_axis_tlast, c % 3 == 2);
        chk("alt_tready", s_axis_tready, e_rdy);
      end
      advance(); drive();
    end
    tick();
    tick();

    // Header slot held full: arbitration stalls until hdr_ready
    p_hready = 0;
    gen_pkt(0, 1, 16'h0800, 4'd5, 8'h11, 16'h1111, 16'h2222, d0);
    gen_pkt(1, 1, 16'h86DD, 4'd0, 8'h11, 16'h3333, 16'h4444, d0);
    drive();
    tick();
    sample();
    chk("bp_first_tdest", m_axis_tdest, 0);
    chk("bp_first_tvalid", m_axis_tvalid, 1);
    advance(); drive();
    for (int c = 0; c < 4; c++) begin
      sample();
      chk("bp_stall_tready", s_axis_tready, 0);
      chk("bp_stall_tvalid", m_axis_tvalid, 0);
      chk("bp_stall_hdr_valid", hdr_valid, 1);
      advance(); drive();
    end
    p_hready = 100;
    hdr_ready = 1'b1;
    sample();
    chk("bp_release_tvalid", m_axis_tvalid, 0);
    advance(); drive();
    sample();
    chk("bp_grant_tvalid", m_axis_tvalid, 1);
    chk("bp_grant_tdest", m_axis_tdest, 1);
    chk("bp_grant_tready", s_axis_tready, 2'b10);
    advance(); drive();
    tick();

    // Asynchronous reset during beat 2 of a 4-beat packet
    p_hready = 0;
    gen_pkt(0, 4, 16'h0800, 4'd5, 8'h06, 16'h5555, 16'h6666, d0);
    gen_pkt(1, 2, 16'h0800, 4'd5, 8'h06, 16'h7777, 16'h8888, d0);
    drive();
    tick();
    tick();
    #1;
    chk("prerst_tvalid", m_axis_tvalid, 1);
    chk("prerst_hdr_valid", hdr_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", m_axis_tvalid, 0);
    chk("arst_tdata", m_axis_tdata, 0);
    chk("arst_tlast", m_axis_tlast, 0);
    chk("arst_tdest", m_axis_tdest, 0);
    chk("arst_tready", s_axis_tready, 0);
    chk("arst_hdr_valid", hdr_valid, 0);
    chk("arst_hdr_class", hdr_class, 0);
    chk("arst_hdr_src", hdr_src_port, 0);
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
    end
    model_reset();
    p_hready = 100;
    drive();
    sample();
    rst_n = 1'b1;
    advance(); drive();
    gen_pkt(0, 1, 16'h0800, 4'd5, 8'h11, 16'h0001, 16'h0002, d0);
    gen_pkt(1, 1, 16'h0800, 4'd5, 8'h11, 16'h0003, 16'h0004, d0);
    drive();
    tick();
    sample();
    chk("postrst_tdest", m_axis_tdest, 0);
    chk("postrst_tvalid", m_axis_tvalid, 1);
    advance(); drive();
    repeat (4) tick();

    // Randomized traffic against the model and scoreboard
    for (int p = 0; p < NP; p++) begin
      for (int k = 0; k < 30; k++) begin
        sel = $urandom_range(0, 3);
        case ($urandom_range(0, 2))
          0: pr = 8'h06;
          1: pr = 8'h11;
          default: pr = 8'($urandom_range(0, 255));
        endcase
        case (sel)
          0: gen_pkt(p, $urandom_range(1, 4), 16'h0800, 4'($urandom_range(5, 6)), pr,
                     16'($urandom()), 16'($urandom()), d0);
          1: gen_pkt(p, $urandom_range(1, 4), 16'h86DD, 4'd0, pr,
                     16'($urandom()), 16'($urandom()), d0);
          2: gen_pkt(p, $urandom_range(1, 4), 16'h88CC, 4'd5, pr,
                     16'($urandom()), 16'($urandom()), d0);
          default: gen_pkt(p, $urandom_range(1, 4), 16'h0800, 4'd5, 8'h11,
                           16'($urandom()), 16'($urandom()), d0);
        endcase
      end
    end
    p_valid = 70;
    p_mready = 75;
    p_hready = 60;
    drive();
    cyc = 0;
    while ((src_q[0].size() > 0 || src_q[1].size() > 0) && cyc < 20000) begin
      tick();
      cyc++;
    end
    if (cyc >= 20000) begin
      n_vec++;
      n_err++;
      $display("FAIL rand_timeout: got %0d beats left, want 0", src_q[0].size() + src_q[1].size());
    end
    p_hready = 100;
    repeat (6) tick();
    chk("sb_drain", exp_q[0].size() + exp_q[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
